// File: rtl/i2c_write_sequencer.sv
// I2C register-write sequencer: START, {addr,W}, reg, data, STOP.
// SDA is open-drain through sda_oe; SCL is driven push-pull.
module i2c_write_sequencer #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  input  logic       sda_in,
  output logic       scl,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err
);
  typedef enum logic [2:0] {
    IDLE, START, BIT, ACK, STOP
  } state_t;

  localparam logic [11:0] DIV_MAX = 12'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [11:0] div_q, div_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  dat_q, dat_d;
  logic        ack_q, ack_d;
  logic        scl_q, scl_d;
  logic        oe_q, oe_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        tick;

  assign tick = busy_q && (div_q == DIV_MAX);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    sh_d    = sh_q;
    reg_d   = reg_q;
    dat_d   = dat_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    if (busy_q)
      div_d = tick ? 12'd0 : div_q + 12'd1;
    if (state_q == ACK && qtr_q == 2'd2 && tick)
      ack_d = sda_in;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          div_d   = 12'd0;
          qtr_d   = 2'd0;
          bit_d   = 3'd0;
          byte_d  = 2'd0;
          sh_d    = {dev_addr, 1'b0};
          reg_d   = reg_addr;
          dat_d   = wr_data;
          busy_d  = 1'b1;
          err_d   = 1'b0;
        end
      end
      default: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            case (state_q)
              START: state_d = BIT;
              BIT: begin
                bit_d = bit_q + 3'd1;
                sh_d  = {sh_q[6:0], 1'b0};
                if (bit_q == 3'd7)
                  state_d = ACK;
              end
              ACK: begin
                if (ack_q) begin
                  err_d   = 1'b1;
                  state_d = STOP;
                end else if (byte_q == 2'd2) begin
                  state_d = STOP;
                end else begin
                  byte_d  = byte_q + 2'd1;
                  sh_d    = (byte_q == 2'd0) ? reg_q : dat_q;
                  state_d = BIT;
                end
              end
              STOP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
              default: state_d = IDLE;
            endcase
          end
        end
      end
    endcase

    // Pin levels are decoded from the next state so they come out registered.
    scl_d = 1'b1;
    oe_d  = 1'b0;
    case (state_d)
      START: begin
        scl_d = ~qtr_d[1];
        oe_d  = (qtr_d != 2'd0);
      end
      BIT: begin
        scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        oe_d  = ~sh_d[7];
      end
      ACK: begin
        scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
        oe_d  = 1'b0;
      end
      STOP: begin
        scl_d = (qtr_d != 2'd0);
        oe_d  = ~qtr_d[1];
      end
      default: begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= 12'd0;
      qtr_q   <= 2'd0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      sh_q    <= 8'd0;
      reg_q   <= 8'd0;
      dat_q   <= 8'd0;
      ack_q   <= 1'b0;
      scl_q   <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      sh_q    <= sh_d;
      reg_q   <= reg_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      scl_q   <= scl_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign scl     = scl_q;
  assign sda_oe  = oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = err_q;
endmodule

// File: doc/i2c_write_sequencer.md
I2C_WRITE_SEQUENCER -- requirements
Module: i2c_write_sequencer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 125: clk cycles per SCL quarter-period, legal range 2..4095.
REQ-002 The block SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request one register-write transaction.
REQ-005 The block SHALL have port dev_addr  input  7  7-bit I2C slave address.
REQ-006 The block SHALL have port reg_addr  input  8  target register index.
REQ-007 The block SHALL have port wr_data  input  8  byte written to reg_addr.
REQ-008 The block SHALL have port sda_in  input  1  sampled SDA line level.
REQ-009 The block SHALL have port scl  output  1  I2C clock, push-pull.
REQ-010 The block SHALL have port sda_oe  output  1  1 = pull SDA low, 0 = release SDA; the SDA pad drives no logic high.
REQ-011 The block SHALL have port busy  output  1  transaction in progress.
REQ-012 The block SHALL have port done  output  1  one-cycle pulse at end of transaction.
REQ-013 The block SHALL have port ack_err  output  1  last transaction saw a NACK; held until the next accepted start.

Function
REQ-014 A free-running quarter tick SHALL fire every CLK_DIV clk cycles while busy; its divider SHALL restart at 0 on accept.
REQ-015 FSM states SHALL be IDLE, START, BIT, ACK, STOP; each non-IDLE state SHALL span 4 quarters q0..q3.
REQ-016 In IDLE, start=1 SHALL be accepted on that edge: dev_addr, reg_addr and wr_data latch, busy=1 and ack_err=0 next cycle, state=START.
REQ-017 While busy, start SHALL be ignored; latched operands SHALL NOT change mid-transaction.
REQ-018 START, (scl,sda_oe) per quarter: q0 (1,0), q1 (1,1), q2 (0,1), q3 (0,1).
REQ-019 BIT: at q0 scl=0 and sda_oe=~bit. At q1 and q2 scl=1. At q3 scl=0. sda_oe SHALL change only in q0.
REQ-020 Bits SHALL shift MSB first. Byte 0 = {dev_addr,1'b0}, byte 1 = reg_addr, byte 2 = wr_data.
REQ-021 After 8 BIT periods the FSM SHALL enter ACK: sda_oe=0, scl timing as BIT, sda_in sampled on the last clk of q2.
REQ-022 ACK sample 0 SHALL continue to the next byte, or to STOP after byte 2.
REQ-023 ACK sample 1 SHALL set ack_err=1 and go directly to STOP, skipping remaining bytes.
REQ-024 STOP, (scl,sda_oe) per quarter: q0 (0,1), q1 (1,1), q2 (1,0), q3 (1,0).
REQ-025 At the end of STOP q3, the next cycle SHALL have state=IDLE, busy=0 and done=1 for exactly one cycle.
REQ-026 A start asserted in the done cycle SHALL be accepted.
REQ-027 A full ACKed transaction SHALL last 116 quarters: 4 START + 3x(8 BIT + 1 ACK)x4 + 4 STOP = 116xCLK_DIV clk cycles from accept to done.
REQ-028 A NACK on byte 0 SHALL yield 4+36+4 = 44 quarters.
REQ-029 In IDLE, outputs SHALL be scl=1 and sda_oe=0.
REQ-030 All outputs SHALL be registered; no output SHALL depend combinationally on inputs.

Reset
REQ-031 reset=1 SHALL on the next edge force state=IDLE, scl=1, sda_oe=0, busy=0, done=0, ack_err=0, divider=0 and bit counter=0.
REQ-032 reset SHALL take priority over start and over every state transition, including mid-transaction; no STOP is generated on abort.
REQ-033 Reset during the done cycle SHALL clear done on the next edge.

Verification
REQ-034 Bench CLK_DIV=4, dev_addr=0x68, reg_addr=0x6B, wr_data=0x00, slave ACKs all bytes -> SDA decodes 0xD0,0x6B,0x00; done exactly 464 cycles after accept; ack_err=0.
REQ-035 Bench same with slave NACK on byte 0 -> ack_err=1; STOP after first ACK slot; done 176 cycles after accept; no further SCL pulses.
REQ-036 Bench start pulsed again 10 cycles after accept with different operands -> ignored; bus shows the original bytes only.
REQ-037 Bench reset asserted at cycle 200 of a transaction -> next cycle scl=1, sda_oe=0, busy=0; a fresh start then completes a normal 464-cycle transaction.
REQ-038 Bench start held high continuously -> back-to-back transactions, each accepted in its done cycle; SDA changes only while scl=0 except for START/STOP edges (checker).
REQ-039 Bench CLK_DIV=2 boundary -> each quarter is exactly 2 cycles; the 116-quarter total holds (232 cycles).
